mem_arbiter: RTL and testbench
==============================

# mem_arbiter

N-port round-robin arbiter that merges several `Memory` master channels onto a single downstream `Memory` slave. It adds an explicit write qualifier: reads return a response and writes do not. An in-order tag FIFO routes each read response back to the port that issued it. The block sits between CPU-side masters (fetch, load/store, DMA) and the single memory or bus port.

## Interface
Parameters:
- N_PORTS, 2, number of upstream master ports (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 4, max outstanding reads; power of 2, ≥2

Ports (up_* are packed arrays, port i occupies slice i):
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- up_m_address  in  N_PORTS*ADDR_W  request address per port
- up_m_data  in  N_PORTS*DATA_W  write data per port
- up_m_write  in  N_PORTS  1=write, 0=read
- up_m_valid  in  N_PORTS  request valid per port
- up_m_ready  out  N_PORTS  request accepted per port
- up_s_data  out  N_PORTS*DATA_W  response data per port
- up_s_valid  out  N_PORTS  response valid per port
- up_s_ready  in  N_PORTS  response ready per port
- dn_m_address, dn_m_data, dn_m_write  out  ADDR_W/DATA_W/1  granted request
- dn_m_valid  out  1;  dn_m_ready  in  1
- dn_s_data  in  DATA_W;  dn_s_valid  in  1;  dn_s_ready  out  1
- outstanding  out  $clog2(DEPTH)+1  reads in flight
- err  out  1  sticky: response arrived with no read outstanding

## Operation
- State: round-robin pointer `rr` (0..N_PORTS-1), tag FIFO of DEPTH entries × $clog2(N_PORTS) bits, count, err flag.
- Eligible port i: up_m_valid[i] && (up_m_write[i] || count<DEPTH). Reads are masked while the FIFO is full; writes are never masked.
- Grant: first eligible port scanning rr, rr+1, …, wrapping mod N_PORTS. Combinational.
- dn_m_valid = any eligible. dn_m_* payload = granted port's payload (zero when no grant).
- up_m_ready[g] = dn_m_ready for granted g. All other up_m_ready are 0.
- Accept (dn_m_valid && dn_m_ready): rr <= g+1 mod N_PORTS. If read, push g into the FIFO.
- No accept: rr holds. A waiting requester keeps its grant while no handshake occurs.
- Response path, FIFO non-empty, head tag h:
  - up_s_valid[h] = dn_s_valid; up_s_data[h] = dn_s_data
  - dn_s_ready = up_s_ready[h]
  - all other up_s_valid are 0; all up_s_data not selected are 0
- Pop on dn_s_valid && dn_s_ready.
- FIFO empty: dn_s_ready=0 and all up_s_valid=0. If dn_s_valid=1 in that state, err <= 1. err holds until reset.
- Simultaneous push and pop: allowed when not full, and count is unchanged. When full, a read is already masked, so a same-cycle pop does not admit a read. That read is accepted no earlier than the next cycle.
- Pointers wrap mod DEPTH. count is the true occupancy, 0..DEPTH.

## Timing
- Request path: zero-cycle combinational pass-through (valid, payload, ready).
- Response path: zero-cycle pass-through.
- State (rr, FIFO, count, err) updates on rising clk only.
- Reset (rst_n=0 at a clk edge), including mid-transaction:
  - rr=0, FIFO empty, count=0, err=0
  - in-flight reads are discarded
- Outputs while rst_n=0 (combinational gating):
  - dn_m_valid=0
  - all up_m_ready=0
  - dn_s_ready=0
  - all up_s_valid=0
- Upstream and downstream must hold valid and payload stable until the handshake. The arbiter does not register or drop a pending request.
- Responses return strictly in request order. Downstream must not reorder.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all up_m_valid=1.
  - Required: dn_m_valid=0, up_m_ready=0, outstanding=0, err=0.
  - After release, port 0 is granted first.
- Fairness: N_PORTS=2, both ports issue continuous writes, dn_m_ready=1.
  - Required: grants alternate 0,1,0,1 for 8 cycles.
- Backpressure: dn_m_ready=0 for 3 cycles with both ports valid.
  - Required: grant stays on port 0 and rr does not move.
  - After ready rises: port 0 handshakes, then port 1.
- Full FIFO, DEPTH=4:
  - Port 0 issues 4 reads: outstanding=4.
  - Port 1 then issues a read and a write: the read is masked, the write is accepted.
  - After one response pop, port 1's read is accepted the following cycle.
- Routing: interleaved reads, port0@0x10, port1@0x20, port0@0x30. Downstream returns 0xA,0xB,0xC.
  - Required: port 0 receives 0xA then 0xC; port 1 receives 0xB.
  - Hold up_s_ready[1]=0 for 2 cycles: dn_s_ready=0 during those cycles.
- Error: dn_s_valid=1 with outstanding=0.
  - Required: dn_s_ready=0, no up_s_valid asserted, err=1 from the next cycle until reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bundled upstream/downstream Memory channels of mem_arbiter
//
// Purpose: groups every bus signal of the arbiter so the block has one port
// besides clk/rst_n. Upstream signals are packed arrays; port i owns slice i.
// Ports (signals):
//   up_m_address/up_m_data/up_m_write/up_m_valid -> arbiter   request per port
//   up_m_ready                                   <- arbiter   request accepted
//   up_s_data/up_s_valid                         <- arbiter   response per port
//   up_s_ready                                   -> arbiter   response ready
//   dn_m_address/dn_m_data/dn_m_write/dn_m_valid <- arbiter   granted request
//   dn_m_ready                                   -> arbiter
//   dn_s_data/dn_s_valid                         -> arbiter   downstream response
//   dn_s_ready                                   <- arbiter
//   outstanding/err                              <- arbiter   status
// Modports: slave = arbiter side, master = environment side.
interface mem_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [N_PORTS*ADDR_W-1:0] up_m_address;
    logic [N_PORTS*DATA_W-1:0] up_m_data;
    logic [N_PORTS-1:0]        up_m_write;
    logic [N_PORTS-1:0]        up_m_valid;
    logic [N_PORTS-1:0]        up_m_ready;
    logic [N_PORTS*DATA_W-1:0] up_s_data;
    logic [N_PORTS-1:0]        up_s_valid;
    logic [N_PORTS-1:0]        up_s_ready;
    logic [ADDR_W-1:0]         dn_m_address;
    logic [DATA_W-1:0]         dn_m_data;
    logic                      dn_m_write;
    logic                      dn_m_valid;
    logic                      dn_m_ready;
    logic [DATA_W-1:0]         dn_s_data;
    logic                      dn_s_valid;
    logic                      dn_s_ready;
    logic [CNT_W-1:0]          outstanding;
    logic                      err;

    modport slave (
        input  up_m_address, up_m_data, up_m_write, up_m_valid, up_s_ready,
               dn_m_ready, dn_s_data, dn_s_valid,
        output up_m_ready, up_s_data, up_s_valid,
               dn_m_address, dn_m_data, dn_m_write, dn_m_valid, dn_s_ready,
               outstanding, err
    );

    modport master (
        output up_m_address, up_m_data, up_m_write, up_m_valid, up_s_ready,
               dn_m_ready, dn_s_data, dn_s_valid,
        input  up_m_ready, up_s_data, up_s_valid,
               dn_m_address, dn_m_data, dn_m_write, dn_m_valid, dn_s_ready,
               outstanding, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port round-robin Memory arbiter with in-order read tag FIFO
//
// Purpose: merges N_PORTS upstream Memory masters onto one downstream slave.
// Writes produce no response; reads push the issuing port number into a tag
// FIFO whose head steers each downstream response back to its requester.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset; also gates all handshake outputs low
//   bus   - mem_arbiter_if.slave carrying all request/response/status signals
module mem_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int TAG_W = $clog2(N_PORTS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] rr_q, rr_d;
    logic [TAG_W-1:0] fifo_q [DEPTH];
    logic [TAG_W-1:0] fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [N_PORTS-1:0] eligible;
    logic               fifo_full;
    logic               fifo_empty;
    logic               grant_vld;
    logic [TAG_W-1:0]   grant_idx;
    logic               accept;
    logic               push;
    logic               pop;
    logic [TAG_W-1:0]   head_tag;
    logic               resp_active;

    function automatic logic [TAG_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        return TAG_W'((base + off) % N_PORTS);
    endfunction

    assign fifo_full   = (count_q == CNT_W'(DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign head_tag    = fifo_q[rd_ptr_q];
    // Response steering only exists while out of reset and a read is in flight.
    assign resp_active = rst_n && !fifo_empty;

    // Reads wait while the tag FIFO is full; writes need no tag so are never held off.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            eligible[i] = rst_n && bus.up_m_valid[i] && (bus.up_m_write[i] || !fifo_full);
        end
    end

    // Round-robin scan starting at rr_q; the pointer only moves on a handshake,
    // so a stalled requester keeps its grant.
    always_comb begin
        logic [TAG_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = wrap_idx(32'(rr_q), 32'(k));
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Request path: zero-cycle pass-through of the granted port.
    always_comb begin
        bus.up_m_ready   = '0;
        bus.dn_m_valid   = grant_vld;
        bus.dn_m_address = '0;
        bus.dn_m_data    = '0;
        bus.dn_m_write   = 1'b0;
        if (grant_vld) begin
            bus.up_m_ready[grant_idx] = bus.dn_m_ready;
            bus.dn_m_address = bus.up_m_address[grant_idx*ADDR_W +: ADDR_W];
            bus.dn_m_data    = bus.up_m_data[grant_idx*DATA_W +: DATA_W];
            bus.dn_m_write   = bus.up_m_write[grant_idx];
        end
    end

    // Response path: the FIFO head names the only port that may see this response.
    always_comb begin
        bus.up_s_valid = '0;
        bus.up_s_data  = '0;
        bus.dn_s_ready = 1'b0;
        if (resp_active) begin
            bus.up_s_valid[head_tag]                 = bus.dn_s_valid;
            bus.up_s_data[head_tag*DATA_W +: DATA_W] = bus.dn_s_data;
            bus.dn_s_ready                           = bus.up_s_ready[head_tag];
        end
    end

    assign accept = grant_vld && bus.dn_m_ready;
    assign push   = accept && !bus.up_m_write[grant_idx];
    assign pop    = resp_active && bus.dn_s_valid && bus.up_s_ready[head_tag];

    always_comb begin
        rr_d     = rr_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (accept) begin
            rr_d = (grant_idx == TAG_W'(N_PORTS - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = grant_idx;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A full FIFO never pushes (reads are masked) and an empty one never pops,
        // so a plain add/subtract stays within 0..DEPTH.
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (fifo_empty && bus.dn_s_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign bus.outstanding = count_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int N_PORTS = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    mem_arbiter #(.N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: rr pointer, queue of issuing ports for reads in flight, sticky error
    int rr_m = 0;
    int tagq[$];
    bit err_m = 0;

    int last_grant;
    bit last_acc, last_pop;
    logic [N_PORTS-1:0]        s_mrdy, s_svld;
    logic [N_PORTS*DATA_W-1:0] s_sdata;
    logic [ADDR_W-1:0]         s_addr;
    logic                      s_dvld, s_dsrdy;
    logic [3:0]                s_out;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        bus.up_m_valid[p] = v;
        bus.up_m_write[p] = w;
        bus.up_m_address[p*ADDR_W +: ADDR_W] = a;
        bus.up_m_data[p*DATA_W +: DATA_W]    = d;
    endtask

    // Entered just after a rising edge with inputs already driven; checks the
    // combinational outputs against the model, then advances one clock.
    task automatic cyc();
        int g, h;
        logic [N_PORTS-1:0]        e_mrdy, e_svld;
        logic [N_PORTS*DATA_W-1:0] e_sdata;
        logic [ADDR_W-1:0]         e_addr;
        logic [DATA_W-1:0]         e_data;
        logic                      e_wr, e_srdy;
        bit                        err_evt, rd;
        #3;
        g = -1;
        if (rst_n) begin
            for (int k = 0; k < N_PORTS; k++) begin
                int p;
                p = (rr_m + k) % N_PORTS;
                if (g < 0 && bus.up_m_valid[p] && (bus.up_m_write[p] || tagq.size() < DEPTH)) g = p;
            end
        end
        e_mrdy = '0; e_addr = '0; e_data = '0; e_wr = 1'b0; rd = 0;
        if (g >= 0) begin
            e_mrdy[g] = bus.dn_m_ready;
            e_addr    = bus.up_m_address[g*ADDR_W +: ADDR_W];
            e_data    = bus.up_m_data[g*DATA_W +: DATA_W];
            e_wr      = bus.up_m_write[g];
            rd        = !bus.up_m_write[g];
        end
        e_svld = '0; e_sdata = '0; e_srdy = 1'b0; h = -1;
        if (rst_n && tagq.size() > 0) begin
            h = tagq[0];
            e_svld[h] = bus.dn_s_valid;
            e_sdata[h*DATA_W +: DATA_W] = bus.dn_s_data;
            e_srdy = bus.up_s_ready[h];
        end
        s_mrdy = bus.up_m_ready; s_svld = bus.up_s_valid; s_sdata = bus.up_s_data;
        s_addr = bus.dn_m_address; s_dvld = bus.dn_m_valid; s_dsrdy = bus.dn_s_ready;
        s_out  = 4'(bus.outstanding);
        check_eq("dn_m_valid", bus.dn_m_valid, g >= 0);
        check_eq("dn_m_address", bus.dn_m_address, e_addr);
        check_eq("dn_m_data", bus.dn_m_data, e_data);
        check_eq("dn_m_write", bus.dn_m_write, e_wr);
        check_eq("up_m_ready", bus.up_m_ready, e_mrdy);
        check_eq("up_s_valid", bus.up_s_valid, e_svld);
        check_eq("up_s_data", bus.up_s_data, e_sdata);
        check_eq("dn_s_ready", bus.dn_s_ready, e_srdy);
        check_eq("outstanding", bus.outstanding, tagq.size());
        check_eq("err", bus.err, err_m);
        last_grant = g;
        last_acc   = (g >= 0) && bus.dn_m_ready;
        last_pop   = (h >= 0) && bus.dn_s_valid && bus.up_s_ready[h];
        err_evt    = rst_n && tagq.size() == 0 && bus.dn_s_valid;
        @(posedge clk);
        if (!rst_n) begin
            tagq.delete(); rr_m = 0; err_m = 0;
        end else begin
            if (last_pop) void'(tagq.pop_front());
            if (err_evt) err_m = 1;
            if (last_acc) begin
                rr_m = (g + 1) % N_PORTS;
                if (rd) tagq.push_back(g);
            end
        end
        #1;
    endtask

    initial begin
        bus.up_m_valid = '1; bus.up_m_write = '1; bus.up_m_address = '0; bus.up_m_data = '0;
        bus.up_s_ready = '1; bus.dn_m_ready = 1'b1; bus.dn_s_valid = 1'b0; bus.dn_s_data = '0;
        set_req(0, 1, 1, 32'h100, 32'h1111);
        set_req(1, 1, 1, 32'h200, 32'h2222);
        @(posedge clk); #1;

        // reset held with every port requesting
        repeat (3) begin
            cyc();
            check_eq("rst_dn_m_valid", s_dvld, 0);
            check_eq("rst_up_m_ready", s_mrdy, 0);
        end
        rst_n = 1'b1;

        // fairness: continuous writes from both ports, port 0 first
        for (int k = 0; k < 8; k++) begin
            cyc();
            check_eq("fair_grant", s_mrdy, 2'b01 << (k % 2));
        end

        // backpressure: grant parks on port 0
        bus.dn_m_ready = 1'b0;
        repeat (3) begin
            cyc();
            check_eq("bp_addr", s_addr, 32'h100);
        end
        bus.dn_m_ready = 1'b1;
        cyc(); check_eq("bp_rel0", s_mrdy, 2'b01);
        cyc(); check_eq("bp_rel1", s_mrdy, 2'b10);

        // full FIFO
        set_req(1, 0, 0, 32'h200, 32'h0);
        set_req(0, 1, 0, 32'h300, 32'h0);
        repeat (4) begin cyc(); check_eq("fill_grant", s_mrdy, 2'b01); end
        set_req(0, 0, 0, 32'h300, 32'h0);
        set_req(1, 1, 0, 32'h400, 32'h0);
        cyc();
        check_eq("full_cnt", s_out, 4);
        check_eq("full_mask", s_dvld, 0);
        set_req(1, 1, 1, 32'h404, 32'h55);
        cyc(); check_eq("full_write", s_mrdy, 2'b10);
        set_req(1, 1, 0, 32'h400, 32'h0);
        bus.dn_s_valid = 1'b1; bus.dn_s_data = 32'hD0;
        cyc();
        check_eq("full_pop_nogrant", s_mrdy, 0);
        check_eq("full_pop_svld", s_svld, 2'b01);
        bus.dn_s_valid = 1'b0;
        cyc(); check_eq("full_read_after_pop", s_mrdy, 2'b10);
        set_req(1, 0, 0, 32'h0, 32'h0);
        bus.dn_s_valid = 1'b1;
        repeat (4) cyc();
        bus.dn_s_valid = 1'b0;
        cyc(); check_eq("drained", s_out, 0);

        // routing: port0@0x10, port1@0x20, port0@0x30
        set_req(0, 1, 0, 32'h10, 32'h0); cyc();
        set_req(0, 0, 0, 32'h10, 32'h0); set_req(1, 1, 0, 32'h20, 32'h0); cyc();
        set_req(1, 0, 0, 32'h20, 32'h0); set_req(0, 1, 0, 32'h30, 32'h0); cyc();
        set_req(0, 0, 0, 32'h30, 32'h0);
        bus.dn_s_valid = 1'b1; bus.dn_s_data = 32'hA; bus.up_s_ready = 2'b11;
        cyc();
        check_eq("route_a_vld", s_svld, 2'b01);
        check_eq("route_a_data", s_sdata[31:0], 32'hA);
        bus.dn_s_data = 32'hB; bus.up_s_ready = 2'b01;
        repeat (2) begin
            cyc();
            check_eq("route_b_stall", s_dsrdy, 0);
            check_eq("route_b_vld", s_svld, 2'b10);
        end
        bus.up_s_ready = 2'b11;
        cyc();
        check_eq("route_b_data", s_sdata[63:32], 32'hB);
        check_eq("route_b_rdy", s_dsrdy, 1);
        bus.dn_s_data = 32'hC;
        cyc();
        check_eq("route_c_vld", s_svld, 2'b01);
        check_eq("route_c_data", s_sdata[31:0], 32'hC);
        bus.dn_s_valid = 1'b0;

        // randomized traffic, with a mid-run reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (!(bus.up_m_valid[i] && !(last_acc && last_grant == i)))
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
            end
            bus.dn_m_ready = $urandom_range(0, 3) != 0;
            if (!(bus.dn_s_valid && !last_pop)) begin
                bus.dn_s_valid = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
                bus.dn_s_data  = $urandom;
            end
            bus.up_s_ready = N_PORTS'($urandom);
            rst_n = (c != 200);
            if (c == 200) bus.dn_s_valid = 1'b0;
            cyc();
        end

        // error: response with nothing outstanding
        bus.up_m_valid = '0; bus.dn_s_valid = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.dn_s_valid = 1'b1; bus.dn_s_data = 32'hEE; bus.up_s_ready = '1;
        cyc();
        check_eq("err_srdy", s_dsrdy, 0);
        check_eq("err_svld", s_svld, 0);
        bus.dn_s_valid = 1'b0;
        repeat (3) begin cyc(); check_eq("err_sticky", bus.err, 1); end
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
